// File: rtl/psum_addr_queue_pkg.sv
// Shared types and default sizes for the partial-sum address queue
// and the aggregator's queue interface.
package psum_addr_queue_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 16;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/psum_addr_queue_addr_fifo.sv
// Show-ahead synchronous FIFO holding generated BRAM word addresses.
// underflow is a single-cycle flag for a pop seen while empty.
module psum_addr_queue_addr_fifo
    import psum_addr_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count,
    output logic                  underflow
);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;
    assign head      = mem[rd_ptr];
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign push_ok   = push && (!full || pop);
    assign pop_ok    = pop && !empty;
    assign underflow = pop && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/psum_addr_queue.sv
// Tile address walker (base + row*stride + col) feeding a show-ahead
// address FIFO consumed by the partial-sum aggregator.
module psum_addr_queue
    import psum_addr_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_num_rows,
    input  logic [CNT_WIDTH-1:0]  cfg_num_cols,
    output logic                  gen_busy,
    output logic                  gen_done,
    output logic                  queue_empty,
    output logic                  queue_full,
    input  logic                  queue_pop,
    output logic [ADDR_WIDTH-1:0] queue_addr,
    output logic [CW-1:0]         queue_count,
    output logic                  underflow_err
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [CNT_WIDTH-1:0]  rows_q;
    logic [CNT_WIDTH-1:0]  cols_q;
    logic [CNT_WIDTH-1:0]  row_cnt_q;
    logic [CNT_WIDTH-1:0]  col_cnt_q;
    logic                  uerr_q;
    logic                  fifo_uf;
    logic                  push;
    logic                  push_ok;
    logic                  last_col;
    logic                  last_row;
    logic                  zero_dim;
    logic                  start_ok;
    logic [ADDR_WIDTH-1:0] push_addr;

    assign zero_dim  = (cfg_num_rows == '0) || (cfg_num_cols == '0);
    assign start_ok  = (state_q == IDLE) && cfg_start;
    assign push      = (state_q == GEN);
    assign push_ok   = push && (!queue_full || queue_pop);
    assign last_col  = (col_cnt_q == cols_q - CNT_WIDTH'(1));
    assign last_row  = (row_cnt_q == rows_q - CNT_WIDTH'(1));
    assign push_addr = row_base_q + ADDR_WIDTH'(col_cnt_q);

    assign gen_busy      = (state_q == GEN);
    assign gen_done      = (state_q == DONE);
    assign underflow_err = uerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = zero_dim ? DONE : GEN;
                end
            end
            GEN: begin
                if (push_ok && last_col && last_row) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A blocked push leaves every counter untouched, so no address is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q   <= '0;
            row_base_q <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
        end else if (start_ok && !zero_dim) begin
            stride_q   <= cfg_row_stride;
            row_base_q <= cfg_base_addr;
            rows_q     <= cfg_num_rows;
            cols_q     <= cfg_num_cols;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
        end else if (push_ok) begin
            if (last_col) begin
                col_cnt_q  <= '0;
                row_cnt_q  <= row_cnt_q + CNT_WIDTH'(1);
                row_base_q <= row_base_q + stride_q;
            end else begin
                col_cnt_q  <= col_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uerr_q <= 1'b0;
        end else if (start_ok) begin
            uerr_q <= 1'b0;
        end else if (fifo_uf) begin
            uerr_q <= 1'b1;
        end
    end

    psum_addr_queue_addr_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_addr),
        .pop        (queue_pop),
        .head       (queue_addr),
        .empty      (queue_empty),
        .full       (queue_full),
        .count      (queue_count),
        .underflow  (fifo_uf)
    );

endmodule

// File: tb/tb_psum_addr_queue.sv
// Bench for psum_addr_queue: queue-based reference of the tile walk and
// FIFO, compared every cycle, plus directed literal checks.
module tb_psum_addr_queue;

    localparam int AW = 32;
    localparam int D  = 4;
    localparam int NW = 16;
    localparam int QW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_row_stride;
    logic [NW-1:0] cfg_num_rows;
    logic [NW-1:0] cfg_num_cols;
    logic          gen_busy;
    logic          gen_done;
    logic          queue_empty;
    logic          queue_full;
    logic          queue_pop;
    logic [AW-1:0] queue_addr;
    logic [QW-1:0] queue_count;
    logic          underflow_err;

    always #5 clk = ~clk;

    psum_addr_queue #(
        .ADDR_WIDTH (AW),
        .DEPTH      (D),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_row_stride (cfg_row_stride),
        .cfg_num_rows   (cfg_num_rows),
        .cfg_num_cols   (cfg_num_cols),
        .gen_busy       (gen_busy),
        .gen_done       (gen_done),
        .queue_empty    (queue_empty),
        .queue_full     (queue_full),
        .queue_pop      (queue_pop),
        .queue_addr     (queue_addr),
        .queue_count    (queue_count),
        .underflow_err  (underflow_err)
    );

    int total = 0;
    int bad   = 0;

    // reference: pending addresses of the walk, and queued addresses
    logic [AW-1:0] pend[$];
    logic [AW-1:0] mq[$];
    bit            mbusy;
    bit            mdone;
    bit            muerr;

    logic [AW-1:0] got[$];
    int            ndone;
    int            pops_at_done;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mq.delete();
        mbusy = 1'b0;
        mdone = 1'b0;
        muerr = 1'b0;
    endtask

    task automatic model_step();
        bit idle;
        int sz;
        bit pop_ok;
        bit under;
        bit push_ok;
        idle    = !mbusy && !mdone;
        sz      = mq.size();
        pop_ok  = queue_pop && (sz > 0);
        under   = queue_pop && (sz == 0);
        push_ok = mbusy && ((sz < D) || queue_pop);
        mdone   = 1'b0;
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) begin
            mq.push_back(pend.pop_front());
            if (pend.size() == 0) begin
                mbusy = 1'b0;
                mdone = 1'b1;
            end
        end
        if (under) muerr = 1'b1;
        if (idle && cfg_start) begin
            muerr = 1'b0;
            if (cfg_num_rows == 0 || cfg_num_cols == 0) begin
                mdone = 1'b1;
            end else begin
                for (int r = 0; r < int'(cfg_num_rows); r++)
                    for (int c = 0; c < int'(cfg_num_cols); c++)
                        pend.push_back(cfg_base_addr + AW'(r) * cfg_row_stride
                                       + AW'(c));
                mbusy = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("busy", gen_busy, mbusy);
        chk("done", gen_done, mdone);
        chk("empty", queue_empty, mq.size() == 0);
        chk("full", queue_full, mq.size() == D);
        chk("count", queue_count, mq.size());
        chk("uerr", underflow_err, muerr);
        if (mq.size() > 0) chk("head", queue_addr, mq[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] s,
                         input int rows, input int cols);
        cfg_base_addr  = b;
        cfg_row_stride = s;
        cfg_num_rows   = NW'(rows);
        cfg_num_cols   = NW'(cols);
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mq.size() > 0 || mbusy || mdone) && n < budget) begin
            queue_pop = (mq.size() > 0);
            tick();
            n++;
        end
        queue_pop = 1'b0;
        chk("drain_bound", n < budget, 1'b1);
    endtask

    logic [AW-1:0] e1 [6];
    int            popp;

    initial begin
        e1 = '{32'h100, 32'h101, 32'h102, 32'h110, 32'h111, 32'h112};
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_base_addr  = '0;
        cfg_row_stride = '0;
        cfg_num_rows   = '0;
        cfg_num_cols   = '0;
        queue_pop      = 1'b0;
        model_reset();
        #3;
        chk("rst_empty", queue_empty, 1'b1);
        chk("rst_busy", gen_busy, 1'b0);
        chk("rst_count", queue_count, 0);
        chk("rst_full", queue_full, 1'b0);
        #9 rst_n = 1'b1;
        tick();

        // 2x3 tile, popped as soon as available
        start(32'h100, 32'h10, 2, 3);
        got.delete();
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            queue_pop = (mq.size() > 0);
            if (queue_pop) got.push_back(queue_addr);
            tick();
            if (gen_done) ndone++;
        end
        queue_pop = 1'b0;
        chk("t1_n", got.size(), 6);
        for (int i = 0; i < 6; i++) chk("t1_addr", got[i], e1[i]);
        chk("t1_done", ndone, 1);
        chk("t1_uerr", underflow_err, 1'b0);

        // 4x4 tile into a 4-deep queue with no pops, then pop continuously
        start(32'h100, 32'h10, 4, 4);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_full", queue_full, 1'b1);
        chk("t2_head", queue_addr, 32'h100);
        chk("t2_busy", gen_busy, 1'b1);
        chk("t2_count", queue_count, 4);
        got.delete();
        pops_at_done = -1;
        for (int i = 0; i < 30; i++) begin
            if (gen_done && pops_at_done < 0) pops_at_done = got.size();
            queue_pop = (mq.size() > 0);
            if (queue_pop) got.push_back(queue_addr);
            tick();
        end
        queue_pop = 1'b0;
        chk("t2_done_at", pops_at_done, 12);
        chk("t2_n", got.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("t2_addr", got[i], 32'h100 + AW'(i / 4) * 32'h10 + AW'(i % 4));

        // zero rows: straight to DONE without pushing
        start(32'h500, 32'h1, 0, 5);
        chk("t4_done", gen_done, 1'b1);
        chk("t4_empty", queue_empty, 1'b1);
        tick();
        chk("t4_done_off", gen_done, 1'b0);
        chk("t4_count", queue_count, 0);

        // pop on empty is sticky until the next start
        queue_pop = 1'b1;
        tick();
        queue_pop = 1'b0;
        chk("t5_uerr", underflow_err, 1'b1);
        tick();
        tick();
        chk("t5_sticky", underflow_err, 1'b1);
        start(32'h40, 32'h1, 1, 1);
        chk("t5_clear", underflow_err, 1'b0);
        drain(20);

        // address wrap
        start(32'hFFFF_FFFF, 32'h5, 1, 2);
        tick();
        tick();
        tick();
        chk("t6_count", queue_count, 2);
        chk("t6_head0", queue_addr, 32'hFFFF_FFFF);
        queue_pop = 1'b1;
        tick();
        chk("t6_head1", queue_addr, 32'h0);
        tick();
        queue_pop = 1'b0;
        chk("t6_empty", queue_empty, 1'b1);

        // asynchronous reset mid-walk with three entries queued
        start(32'h200, 32'h10, 4, 4);
        tick();
        tick();
        tick();
        chk("t7_count", queue_count, 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t7_busy", gen_busy, 1'b0);
        chk("t7_empty", queue_empty, 1'b1);
        chk("t7_cnt", queue_count, 0);
        chk("t7_done", gen_done, 1'b0);
        chk("t7_uerr", underflow_err, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        start(32'h300, 32'h10, 1, 2);
        tick();
        tick();
        chk("t7_head", queue_addr, 32'h300);
        drain(20);

        // randomized traffic, including starts while busy
        for (int seg = 0; seg < 6; seg++) begin
            popp = (seg == 0) ? 15 : (seg == 1) ? 50 : (seg == 2) ? 100
                 : (seg == 3) ? 85 : (seg == 4) ? 30 : 70;
            for (int i = 0; i < 500; i++) begin
                cfg_start      = ($urandom_range(0, 9) == 0);
                cfg_base_addr  = $urandom;
                cfg_row_stride = ($urandom_range(0, 3) == 0) ? $urandom
                               : AW'($urandom_range(0, 64));
                cfg_num_rows   = NW'($urandom_range(0, 5));
                cfg_num_cols   = NW'($urandom_range(0, 6));
                queue_pop      = !cfg_start && ($urandom_range(0, 99) < popp);
                tick();
            end
        end
        cfg_start = 1'b0;
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
